// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//   Boot-time loader in front of the NanoRisc core. Accepts a framed byte
//   stream (LEN, N payload bytes, CHK), writes the payload into instruction
//   memory via its write port, and releases the core only once the image
//   checksum verifies.
//
//   State table
//     state   | meaning
//     IDLE    | after reset, waiting for start
//     LEN     | waiting for the length byte N (1..255)
//     DATA    | receiving payload bytes, one memory write per accept
//     CHECK   | waiting for the checksum byte
//     RUN     | image verified, core released (cpuRun=1)
//     ERROR   | bad length, bad checksum or byte timeout; core held
//
// Ports
//   clock_i        system clock, rising edge
//   resetN_i       asynchronous active-low reset
//   start_i        1-cycle pulse, begins a load from IDLE, RUN or ERROR
//   byteValid_i    source presents a byte on byteData_i
//   byteData_i     stream byte
//   byteReady_o    loader accepts a byte this cycle (LEN, DATA, CHECK)
//   imemWrite_o    instruction memory write strobe (registered)
//   imemAddress_o  instruction memory write address (held when idle)
//   imemData_o     instruction memory write data (held when idle)
//   cpuRun_o       1 = core released, 0 = core held
//   loadDone_o     1-cycle pulse on a verified image
//   loadError_o    high while in ERROR
// -----------------------------------------------------------------------------
module program_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int START_ADDR = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clock_i,
    input  logic                  resetN_i,
    input  logic                  start_i,
    input  logic                  byteValid_i,
    input  logic [DATA_WIDTH-1:0] byteData_i,
    output logic                  byteReady_o,
    output logic                  imemWrite_o,
    output logic [ADDR_WIDTH-1:0] imemAddress_o,
    output logic [DATA_WIDTH-1:0] imemData_o,
    output logic                  cpuRun_o,
    output logic                  loadDone_o,
    output logic                  loadError_o
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT);
    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(START_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] len_q, len_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;

    logic                  ready;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sum_plus_byte;

    always_ff @(posedge clock_i or negedge resetN_i) begin
        if (!resetN_i) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            count_q <= '0;
            sum_q   <= '0;
            timer_q <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            timer_q <= timer_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign ready         = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHECK);
    assign accept        = byteValid_i && ready;
    assign sum_plus_byte = sum_q + byteData_i;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        sum_d   = sum_q;
        timer_d = timer_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE, S_RUN, S_ERROR: begin
                if (start_i) begin
                    state_d = S_LEN;
                    timer_d = TIMER_LOAD;
                end
            end
            S_LEN: begin
                if (accept) begin
                    if (byteData_i == '0) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA;
                        len_d   = byteData_i;
                        count_d = '0;
                        sum_d   = '0;
                        timer_d = TIMER_LOAD;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    wr_d    = 1'b1;
                    addr_d  = BASE_ADDR + ADDR_WIDTH'(count_q);
                    data_d  = byteData_i;
                    sum_d   = sum_plus_byte;
                    count_d = count_q + 1'b1;
                    timer_d = TIMER_LOAD;
                    if (count_q == len_q - 1'b1) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (accept) begin
                    if (sum_plus_byte == '0) begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Idle-gap timer counts down from TIMEOUT; the cycle it would pass
        // through 1 is the TIMEOUT-th consecutive cycle without a byte.
        if (TIMEOUT_EN && ready && !accept) begin
            timer_d = timer_q - 1'b1;
            if (timer_q == TW'(1)) begin
                state_d = S_ERROR;
            end
        end
    end

    assign byteReady_o   = ready;
    assign imemWrite_o   = wr_q;
    assign imemAddress_o = addr_q;
    assign imemData_o    = data_q;
    assign cpuRun_o      = (state_q == S_RUN);
    assign loadDone_o    = done_q;
    assign loadError_o   = (state_q == S_ERROR);

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    typedef logic [7:0] bq_t[$];

    logic       clock = 1'b0;
    logic       resetN = 1'b0;
    logic       start = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;

    // instance a: defaults; w: START_ADDR=FE; t: TIMEOUT=4
    logic       ready_a, wr_a, run_a, done_a, err_a;
    logic [7:0] addr_a, data_a;
    logic       ready_w, wr_w, run_w, done_w, err_w;
    logic [7:0] addr_w, data_w;
    logic       ready_t, wr_t, run_t, done_t, err_t;
    logic [7:0] addr_t, data_t;

    int total = 0;
    int bad   = 0;

    int         cyc = 0;
    logic [7:0] log_a_addr [64];
    logic [7:0] log_a_data [64];
    int         log_a_cyc  [64];
    int         wr_n_a = 0;
    int         done_n_a = 0;
    logic [7:0] log_w_addr [64];
    logic [7:0] log_w_data [64];
    int         wr_n_w = 0;

    program_loader u_dut (
        .clock_i(clock), .resetN_i(resetN), .start_i(start),
        .byteValid_i(byte_valid), .byteData_i(byte_data),
        .byteReady_o(ready_a), .imemWrite_o(wr_a), .imemAddress_o(addr_a),
        .imemData_o(data_a), .cpuRun_o(run_a), .loadDone_o(done_a),
        .loadError_o(err_a)
    );

    program_loader #(.START_ADDR(8'hFE)) u_wrap (
        .clock_i(clock), .resetN_i(resetN), .start_i(start),
        .byteValid_i(byte_valid), .byteData_i(byte_data),
        .byteReady_o(ready_w), .imemWrite_o(wr_w), .imemAddress_o(addr_w),
        .imemData_o(data_w), .cpuRun_o(run_w), .loadDone_o(done_w),
        .loadError_o(err_w)
    );

    program_loader #(.TIMEOUT(4)) u_to (
        .clock_i(clock), .resetN_i(resetN), .start_i(start),
        .byteValid_i(byte_valid), .byteData_i(byte_data),
        .byteReady_o(ready_t), .imemWrite_o(wr_t), .imemAddress_o(addr_t),
        .imemData_o(data_t), .cpuRun_o(run_t), .loadDone_o(done_t),
        .loadError_o(err_t)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc = cyc + 1;
        if (wr_a === 1'b1 && wr_n_a < 64) begin
            log_a_addr[wr_n_a] = addr_a;
            log_a_data[wr_n_a] = data_a;
            log_a_cyc[wr_n_a]  = cyc;
            wr_n_a = wr_n_a + 1;
        end
        if (done_a === 1'b1) done_n_a = done_n_a + 1;
        if (wr_w === 1'b1 && wr_n_w < 64) begin
            log_w_addr[wr_n_w] = addr_w;
            log_w_data[wr_n_w] = data_w;
            wr_n_w = wr_n_w + 1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic rdy(input int which);
        if (which == 1) return ready_w;
        if (which == 2) return ready_t;
        return ready_a;
    endfunction

    task automatic do_reset();
        resetN = 1'b0;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        tick();
        tick();
        resetN = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input bq_t q, input int which);
        int n;
        byte_valid = 1'b1;
        foreach (q[i]) begin
            byte_data = q[i];
            n = 0;
            while (!rdy(which) && n < 20) begin
                tick();
                n++;
            end
            total++;
            if (n == 20) begin
                bad++;
                $display("FAIL send_ready: byteReady stuck low for byte %0d, required 1", i);
            end
            tick();
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        resetN = 1'b0;
        #1;
        total++;
        if ({ready_a, wr_a, addr_a, data_a, run_a, done_a, err_a} !== 21'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h required 0",
                     {ready_a, wr_a, addr_a, data_a, run_a, done_a, err_a});
        end
        resetN = 1'b1;
        tick();
        total++;
        if (ready_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_ready: got %b required 0", ready_a);
        end
    endtask

    task automatic test_good_frame();
        bq_t f;
        int base, dbase;
        logic [7:0] ed [3];
        ed[0] = 8'h11; ed[1] = 8'h22; ed[2] = 8'h33;
        do_reset();
        base = wr_n_a;
        dbase = done_n_a;
        pulse_start();
        f = {8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
        send(f, 0);
        total++;
        if (run_a !== 1'b1 || done_a !== 1'b1 || err_a !== 1'b0) begin
            bad++;
            $display("FAIL good_done_run: run=%b done=%b err=%b required 1 1 0", run_a, done_a, err_a);
        end
        tick();
        total++;
        if (done_a !== 1'b0 || done_n_a - dbase != 1) begin
            bad++;
            $display("FAIL good_done_pulse: done=%b pulses=%0d required 0 1", done_a, done_n_a - dbase);
        end
        total++;
        if (wr_n_a - base != 3) begin
            bad++;
            $display("FAIL good_write_count: got %0d required 3", wr_n_a - base);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (log_a_addr[base+i] !== 8'(i) || log_a_data[base+i] !== ed[i]) begin
                bad++;
                $display("FAIL good_write_%0d: got %h@%h required %h@%h",
                         i, log_a_data[base+i], log_a_addr[base+i], ed[i], 8'(i));
            end
        end
    endtask

    task automatic test_bad_checksum();
        bq_t f;
        int base;
        do_reset();
        base = wr_n_a;
        pulse_start();
        f = {8'h03, 8'h11, 8'h22, 8'h33, 8'h9B};
        send(f, 0);
        total++;
        if (err_a !== 1'b1 || run_a !== 1'b0 || wr_n_a - base != 3) begin
            bad++;
            $display("FAIL badchk_error: err=%b run=%b writes=%0d required 1 0 3",
                     err_a, run_a, wr_n_a - base);
        end
        pulse_start();
        total++;
        if (err_a !== 1'b0 || ready_a !== 1'b1) begin
            bad++;
            $display("FAIL badchk_restart: err=%b ready=%b required 0 1", err_a, ready_a);
        end
        f = {8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
        send(f, 0);
        total++;
        if (run_a !== 1'b1 || err_a !== 1'b0) begin
            bad++;
            $display("FAIL badchk_recover: run=%b err=%b required 1 0", run_a, err_a);
        end
    endtask

    task automatic test_zero_len();
        bq_t f;
        int base;
        do_reset();
        base = wr_n_a;
        pulse_start();
        f = {8'h00};
        send(f, 0);
        total++;
        if (err_a !== 1'b1 || run_a !== 1'b0) begin
            bad++;
            $display("FAIL zerolen_error: err=%b run=%b required 1 0", err_a, run_a);
        end
        tick();
        tick();
        total++;
        if (wr_n_a - base != 0) begin
            bad++;
            $display("FAIL zerolen_no_write: writes=%0d required 0", wr_n_a - base);
        end
    endtask

    task automatic test_addr_wrap();
        bq_t f;
        int base;
        logic [7:0] ea [3];
        logic [7:0] ed [3];
        ea[0] = 8'hFE; ea[1] = 8'hFF; ea[2] = 8'h00;
        ed[0] = 8'h01; ed[1] = 8'h02; ed[2] = 8'h03;
        do_reset();
        base = wr_n_w;
        pulse_start();
        f = {8'h03, 8'h01, 8'h02, 8'h03, 8'hFA};
        send(f, 1);
        tick();
        total++;
        if (wr_n_w - base != 3 || run_w !== 1'b1) begin
            bad++;
            $display("FAIL wrap_count_run: writes=%0d run=%b required 3 1", wr_n_w - base, run_w);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (log_w_addr[base+i] !== ea[i] || log_w_data[base+i] !== ed[i]) begin
                bad++;
                $display("FAIL wrap_write_%0d: got %h@%h required %h@%h",
                         i, log_w_data[base+i], log_w_addr[base+i], ed[i], ea[i]);
            end
        end
    endtask

    task automatic test_timeout();
        bq_t f;
        do_reset();
        pulse_start();
        f = {8'h02, 8'hAA};
        send(f, 2);
        tick();
        tick();
        tick();
        total++;
        if (err_t !== 1'b0 || ready_t !== 1'b1) begin
            bad++;
            $display("FAIL timeout_early: err=%b ready=%b after 3 idle, required 0 1", err_t, ready_t);
        end
        tick();
        total++;
        if (err_t !== 1'b1 || run_t !== 1'b0) begin
            bad++;
            $display("FAIL timeout_error: err=%b run=%b after 4 idle, required 1 0", err_t, run_t);
        end
    endtask

    task automatic test_back_to_back();
        bq_t f;
        int base;
        do_reset();
        pulse_start();
        f = {8'h03, 8'h11, 8'h22};
        send(f, 0);
        total++;
        if (wr_a !== 1'b1 || addr_a !== 8'h01 || data_a !== 8'h22) begin
            bad++;
            $display("FAIL midload_write: wr=%b %h@%h required 1 22@01", wr_a, data_a, addr_a);
        end
        #2;
        resetN = 1'b0;
        #1;
        total++;
        if ({ready_a, wr_a, addr_a, data_a, run_a, done_a, err_a} !== 21'h0) begin
            bad++;
            $display("FAIL async_reset: got %h required 0",
                     {ready_a, wr_a, addr_a, data_a, run_a, done_a, err_a});
        end
        tick();
        resetN = 1'b1;
        tick();
        total++;
        if (ready_a !== 1'b0 || run_a !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle: ready=%b run=%b required 0 0", ready_a, run_a);
        end
        base = wr_n_a;
        pulse_start();
        f = {8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
        send(f, 0);
        tick();
        total++;
        if (wr_n_a - base != 3 || run_a !== 1'b1) begin
            bad++;
            $display("FAIL b2b_count_run: writes=%0d run=%b required 3 1", wr_n_a - base, run_a);
        end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (log_a_cyc[base+i+1] - log_a_cyc[base+i] != 1) begin
                bad++;
                $display("FAIL b2b_gap_%0d: gap=%0d required 1", i,
                         log_a_cyc[base+i+1] - log_a_cyc[base+i]);
            end
        end
        // In RUN: start and a byte together; start wins and the byte is dropped.
        start = 1'b1;
        byte_valid = 1'b1;
        byte_data = 8'h03;
        tick();
        start = 1'b0;
        byte_valid = 1'b0;
        total++;
        if (run_a !== 1'b0 || ready_a !== 1'b1) begin
            bad++;
            $display("FAIL run_restart: run=%b ready=%b required 0 1", run_a, ready_a);
        end
        f = {8'h01, 8'h55, 8'hAB};
        send(f, 0);
        total++;
        if (run_a !== 1'b1 || err_a !== 1'b0) begin
            bad++;
            $display("FAIL start_wins: run=%b err=%b required 1 0", run_a, err_a);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_zero_len();
        test_addr_wrap();
        test_timeout();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
